response_sender: RTL
====================

Name: response_sender

Overview:
- Transmit-side counterpart of the FTDI command parser.
- Takes a decoded read command (header, address, length) and fetches `length` bytes from the local register file, one byte per register access.
- Pushes a response frame into the FTDI transmit FIFO: optional 4-byte echo header, then the data bytes.
- Sits between the command decoder / register bank and the FTDI write port.

Parameters:
- ADDR_INC, 1, 1 = register address increments after each fetched byte (8-bit wrap); 0 = address held constant (FIFO-style register).
- ECHO_HEADER, 1, 1 = send header, address, length[15:8], length[7:0] before the data; 0 = data bytes only.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- res  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command fields valid.
- cmd_ready  out  1  block idle, command accepted this cycle if cmd_valid=1.
- cmd_header  in  8  command header; bit0 = 1 for write, 0 for read.
- cmd_address  in  8  start register address.
- cmd_length  in  16  byte count, 0..65535.
- reg_addr  out  8  register address for fetch.
- reg_rd  out  1  register read strobe, one cycle per byte.
- reg_rdata  in  8  register data, valid exactly one cycle after reg_rd.
- wo_data  out  8  byte to FTDI TX FIFO.
- wo_write  out  1  write enable to FTDI TX FIFO.
- wo_full  in  1  FTDI TX FIFO full.
- busy  out  1  frame in progress (state != IDLE).
- state  out  4  debug: current state code.

Behaviour:
- Reset, asynchronous on `res`, effective immediately regardless of clock:
  - State goes to IDLE.
  - reg_rd=0, wo_write=0, wo_data=0, reg_addr=0, busy=0, state=0.
  - All internal header, address, length and data latches cleared.
  - A partially sent frame is abandoned; nothing resumes after reset release.
- State codes: IDLE=0000, HDR=0001, ADR=0010, LEN_A=0011, LEN_B=0100, FETCH=0101, LATCH=0110, SEND=0111.
- cmd_ready = (state == IDLE), combinational.
- Command acceptance, on an edge with cmd_valid & cmd_ready:
  - All three command fields are latched and the address counter is loaded.
  - If header[0]=1 (write command): stay in IDLE. No output, no reg_rd; the command is dropped.
  - If a read command and ECHO_HEADER=1: go to HDR.
  - If a read command, ECHO_HEADER=0 and length!=0: go to FETCH.
  - If a read command, ECHO_HEADER=0 and length=0: stay in IDLE.
- Echo states (HDR, ADR, LEN_A, LEN_B):
  - wo_data = latched header / address / length[15:8] / length[7:0] respectively (header echoed unchanged; address is the start address).
  - wo_write = !wo_full, combinational.
  - Advance only on an edge with wo_write=1; while wo_full=1, hold state and wo_data.
  - LEN_B exits to FETCH if length!=0, otherwise to IDLE.
- FETCH: reg_rd=1 and reg_addr = address counter, for exactly one cycle. Go to LATCH unconditionally.
- LATCH: capture reg_rdata into the data register; go to SEND.
- SEND:
  - wo_data = data register; wo_write = !wo_full.
  - On a write edge: decrement the remaining count; if ADDR_INC=1, address counter +1 (0xFF wraps to 0x00).
  - Next state is IDLE if the remaining count was 1, else FETCH.
  - While wo_full=1: hold state. No new reg_rd is issued, so no register read side-effect is repeated.
- reg_addr holds the address counter value in all states; it is meaningful only while reg_rd=1.
- Throughput:
  - 3 cycles per data byte with wo_full=0; 1 cycle per echo byte.
  - Full 4-byte echo plus N data bytes: 4+3N cycles from the accept edge to the return to IDLE.
- The remaining-byte counter is 16 bit; length 65535 is sent completely with no overflow.
- wo_write is never asserted while wo_full=1. Each frame byte is written exactly once, in order.
- cmd_valid is ignored while busy; the upstream must hold the command until cmd_ready.

Test Plan:
- Basic read, wo_full=0:
  - Stimulus: cmd header 0x02, addr 0x10, len 3; regs 0x10..0x12 = A1, A2, A3.
  - Required: wo stream 02 10 00 03 A1 A2 A3; reg_rd pulses with reg_addr 10, 11, 12; busy for 13 cycles; cmd_ready high afterwards.
- Backpressure:
  - Stimulus: same command; wo_full=1 for 5 cycles starting when SEND holds A2.
  - Required: wo_write=0 during the stall; wo_data stays A2; exactly 3 reg_rd pulses; stream identical to the basic-read case.
- Zero length:
  - Stimulus: header 0x00, addr 0x20, len 0.
  - Required: stream 00 20 00 00; no reg_rd. With ECHO_HEADER=0: no wo_write at all and cmd_ready stays high.
- Wrap and hold:
  - Stimulus: addr 0xFE, len 3.
  - Required: reg_addr FE, FF, 00. With ADDR_INC=0: FE, FE, FE.
- Write command:
  - Stimulus: header 0x01, len 5.
  - Required: no wo_write, no reg_rd; cmd_ready=1 on the next cycle.
- Reset mid-frame:
  - Stimulus: assert res asynchronously during the second data byte.
  - Required: wo_write, reg_rd, busy and state drop to 0 before the next clock edge. A following read command produces a complete, correct frame.

Source files
------------

// File: rtl/response_sender.sv
// Response frame transmitter: fetches a run of register bytes for a read command and pushes
// an optional echo header plus the data bytes into the FTDI transmit FIFO.
module response_sender #(
   parameter bit ADDR_INC    = 1'b1,
   parameter bit ECHO_HEADER = 1'b1
) (
   input  logic        clk,
   input  logic        res,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_header,
   input  logic [7:0]  cmd_address,
   input  logic [15:0] cmd_length,
   output logic [7:0]  reg_addr,
   output logic        reg_rd,
   input  logic [7:0]  reg_rdata,
   output logic [7:0]  wo_data,
   output logic        wo_write,
   input  logic        wo_full,
   output logic        busy,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StHdr   = 4'd1,
      StAdr   = 4'd2,
      StLenA  = 4'd3,
      StLenB  = 4'd4,
      StFetch = 4'd5,
      StLatch = 4'd6,
      StSend  = 4'd7
   } state_e;

   state_e      state_q;
   logic [7:0]  hdr_q;
   logic [7:0]  addr_q;
   logic [15:0] len_q;
   logic [15:0] cnt_q;
   logic [7:0]  data_q;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= StIdle;
         hdr_q   <= 8'h00;
         addr_q  <= 8'h00;
         len_q   <= 16'h0000;
         cnt_q   <= 16'h0000;
         data_q  <= 8'h00;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  hdr_q  <= cmd_header;
                  addr_q <= cmd_address;
                  len_q  <= cmd_length;
                  cnt_q  <= cmd_length;
                  // Write commands are latched but dropped; only reads produce a frame.
                  if (!cmd_header[0]) begin
                     if (ECHO_HEADER) begin
                        state_q <= StHdr;
                     end else if (cmd_length != 16'h0000) begin
                        state_q <= StFetch;
                     end
                  end
               end
            end
            StHdr: begin
               if (!wo_full) state_q <= StAdr;
            end
            StAdr: begin
               if (!wo_full) state_q <= StLenA;
            end
            StLenA: begin
               if (!wo_full) state_q <= StLenB;
            end
            StLenB: begin
               if (!wo_full) state_q <= (len_q != 16'h0000) ? StFetch : StIdle;
            end
            StFetch: begin
               state_q <= StLatch;
            end
            StLatch: begin
               data_q  <= reg_rdata;
               state_q <= StSend;
            end
            StSend: begin
               // Holding here under backpressure keeps reg_rd low, so no read side-effect repeats.
               if (!wo_full) begin
                  cnt_q <= cnt_q - 16'd1;
                  if (ADDR_INC) addr_q <= addr_q + 8'd1;
                  state_q <= (cnt_q == 16'd1) ? StIdle : StFetch;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      wo_data  = 8'h00;
      wo_write = 1'b0;
      case (state_q)
         StHdr: begin
            wo_data  = hdr_q;
            wo_write = !wo_full;
         end
         StAdr: begin
            wo_data  = addr_q;
            wo_write = !wo_full;
         end
         StLenA: begin
            wo_data  = len_q[15:8];
            wo_write = !wo_full;
         end
         StLenB: begin
            wo_data  = len_q[7:0];
            wo_write = !wo_full;
         end
         StSend: begin
            wo_data  = data_q;
            wo_write = !wo_full;
         end
         default: begin
            wo_data  = 8'h00;
            wo_write = 1'b0;
         end
      endcase
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign reg_rd    = (state_q == StFetch);
   assign reg_addr  = addr_q;
   assign state     = state_q;

endmodule
